snake_body_tracker: RTL

//  Upstream of the apple generator. Holds snake head/body coordinates and advances one cell per move tick.

---
 rtl/snake_body_tracker_if.sv | 29 ++
 rtl/snake_body_tracker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/snake_body_tracker_if.sv
// Snake tracker bus: move controls from the game controller and the body /
// status view that the apple generator and display consume.
//   start, step, dir, apple_xy : controller -> tracker
//   body, length               : tracker -> consumers (body[0] = head)
//   goodColl, badColl, alive   : tracker -> consumers (status)
// master = controller side, slave = tracker side.
interface snake_body_tracker_if #(
  parameter int MAX_LEN = 50
);
  logic                      start;
  logic                      step;
  logic [1:0]                dir;
  logic [7:0]                apple_xy;
  logic [MAX_LEN-1:0][7:0]   body;
  logic [5:0]                length;
  logic                      goodColl;
  logic                      badColl;
  logic                      alive;

  modport master (
    output start, step, dir, apple_xy,
    input  body, length, goodColl, badColl, alive
  );

  modport slave (
    input  start, step, dir, apple_xy,
    output body, length, goodColl, badColl, alive
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body tracker: holds head/body coordinates ({x,y} nibbles, 16x16 grid),
// moves one cell per step pulse, grows when the head lands on the apple and
// detects wall/self collisions.
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - synchronous active-high reset, overrides everything
//   bus   - snake_body_tracker_if.slave (controls in, body/status out)
// All outputs are registered and change the cycle after the step that causes them.
module snake_body_tracker #(
  parameter int         MAX_LEN   = 50,
  parameter int         INIT_LEN  = 3,
  parameter logic [7:0] INIT_HEAD = 8'h58
) (
  input  logic                  clk,
  input  logic                  reset,
  snake_body_tracker_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t                  state_q;
  logic [1:0]              cur_dir_q;
  logic [MAX_LEN-1:0][7:0] body_q;
  logic [5:0]              len_q;
  logic                    good_q;
  logic                    bad_q;
  logic                    alive_q;

  logic [MAX_LEN-1:0][7:0] init_body;
  logic [MAX_LEN-1:0][7:0] body_d;
  logic [5:0]              len_d;
  logic [1:0]              dir_eff;
  logic [3:0]              hx, hy;
  logic [7:0]              new_head;
  logic [7:0]              tail_d;
  logic                    wall_hit, self_hit, grow;

  // Reset image: a horizontal line trailing left of the head; slots past the
  // tail repeat the tail so no free cell is ever named.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_init
      localparam int IDX = (gi < INIT_LEN) ? gi : INIT_LEN - 1;
      assign init_body[gi] = {4'(int'(INIT_HEAD[7:4]) - IDX), INIT_HEAD[3:0]};
    end
  endgenerate

  always_comb begin
    // A direct reversal would fold the head into the neck; keep the old heading.
    dir_eff  = (bus.dir == {cur_dir_q[1], ~cur_dir_q[0]}) ? cur_dir_q : bus.dir;
    hx       = body_q[0][7:4];
    hy       = body_q[0][3:0];
    wall_hit = 1'b0;
    case (dir_eff)
      2'b00:   begin wall_hit = (hy == 4'd0);  hy = hy - 4'd1; end
      2'b01:   begin wall_hit = (hy == 4'd15); hy = hy + 4'd1; end
      2'b10:   begin wall_hit = (hx == 4'd0);  hx = hx - 4'd1; end
      default: begin wall_hit = (hx == 4'd15); hx = hx + 4'd1; end
    endcase
    new_head = {hx, hy};
    grow     = (new_head == bus.apple_xy);

    // The tail cell is free to enter only if the tail actually moves away.
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_q) && (grow || i != int'(len_q) - 1) && body_q[i] == new_head)
        self_hit = 1'b1;
    end

    len_d  = (grow && len_q != 6'(MAX_LEN)) ? len_q + 6'd1 : len_q;
    // New tail sits at slot len_d-1, which after the shift holds body_q[len_d-2].
    tail_d = body_q[len_d - 6'd2];
  end

  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign body_d[gi] = new_head;
      end else begin : g_tail
        assign body_d[gi] = (gi >= int'(len_d) - 1) ? tail_d : body_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_dir_q <= 2'b11;
      body_q    <= init_body;
      len_q     <= 6'(INIT_LEN);
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      alive_q   <= 1'b1;
    end else begin
      good_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) state_q <= S_RUN;
        S_RUN: begin
          if (bus.step) begin
            cur_dir_q <= dir_eff;
            if (wall_hit || self_hit) begin
              // Collision wins over eating: body and length stay as they were.
              bad_q   <= 1'b1;
              alive_q <= 1'b0;
              state_q <= S_DEAD;
            end else begin
              body_q <= body_d;
              len_q  <= len_d;
              good_q <= grow;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.body     = body_q;
  assign bus.length   = len_q;
  assign bus.goodColl = good_q;
  assign bus.badColl  = bad_q;
  assign bus.alive    = alive_q;

endmodule
